// File: rtl/threshold_pkg.sv
// Shared constants, occupancy state encoding and counter-width helper for the
// threshold actor slice.
package threshold_pkg;

  localparam int unsigned PIXEL_W     = 8;
  localparam logic [7:0]  FG_VAL      = 8'hFF;
  localparam logic [7:0]  BG_VAL      = 8'h00;
  localparam logic [15:0] TOKEN_COUNT = 16'h1;

  // Occupancy of the two-entry token buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Ceiling log2; clog2(n + 1) gives the width needed to hold the value n.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/threshold_actor_if.sv
// Token stream bundle for the threshold actor.
//   In1_*  : pixel stream into the actor (DATA/SEND/COUNT from producer, ACK back)
//   Out1_* : binarised stream out of the actor (DATA/SEND/COUNT out, RDY/ACK back)
// master = environment side (producer + consumer), slave = actor side.
interface threshold_actor_if;
  import threshold_pkg::*;

  logic [PIXEL_W-1:0] In1_DATA;
  logic               In1_SEND;
  logic [15:0]        In1_COUNT;
  logic               In1_ACK;

  logic [PIXEL_W-1:0] Out1_DATA;
  logic               Out1_SEND;
  logic [15:0]        Out1_COUNT;
  logic               Out1_RDY;
  logic               Out1_ACK;

  modport master (
    output In1_DATA, In1_SEND, In1_COUNT,
    input  In1_ACK,
    input  Out1_DATA, Out1_SEND, Out1_COUNT,
    output Out1_RDY, Out1_ACK
  );

  modport slave (
    input  In1_DATA, In1_SEND, In1_COUNT,
    output In1_ACK,
    output Out1_DATA, Out1_SEND, Out1_COUNT,
    input  Out1_RDY, Out1_ACK
  );

endinterface

// File: rtl/threshold_fifo2.sv
// Two-entry, 8-bit synchronous FIFO with asynchronous active-high reset.
//   clk, rst   : clock, async reset (clears contents)
//   push, din  : write din at the next edge (ignored when full without pop)
//   pop        : drop the head at the next edge (ignored when empty)
//   dout       : current head (slot0)
//   empty/full : occupancy flags decoded from the state register
module threshold_fifo2
  import threshold_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [PIXEL_W-1:0] din,
  output logic [PIXEL_W-1:0] dout,
  output logic               empty,
  output logic               full
);

  occ_e               occ;
  logic [PIXEL_W-1:0] slot0;
  logic [PIXEL_W-1:0] slot1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= OCC_EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            slot0 <= din;
            occ   <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push, pop})
            2'b10: begin
              slot1 <= din;
              occ   <= OCC_FULL;
            end
            2'b01: occ <= OCC_EMPTY;
            // Head leaves and the new token takes its place: order is kept.
            2'b11: slot0 <= din;
            default: ;
          endcase
        end
        OCC_FULL: begin
          if (pop) begin
            slot0 <= slot1;
            if (push) slot1 <= din;
            else      occ   <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  assign dout  = slot0;
  assign empty = (occ == OCC_EMPTY);
  assign full  = (occ == OCC_FULL);

endmodule

// File: rtl/threshold_actor.sv
// Threshold actor: binarises an 8-bit pixel stream (FG_VAL when pixel > THRESHOLD,
// BG_VAL otherwise) through a two-entry token buffer and counts foreground pixels
// per frame of FRAME_PIXELS tokens.
//   CLK, RESET : clock, asynchronous active-high reset
//   io         : In1_* pixel input stream, Out1_* binarised output stream
//   FRAME_FG   : foreground count of the last completed frame
//   FRAME_DONE : one-cycle pulse when FRAME_FG updates
module threshold_actor
  import threshold_pkg::*;
#(
  parameter logic [7:0]  THRESHOLD    = 8'd128,
  parameter int unsigned FRAME_PIXELS = 262144
) (
  input  logic               CLK,
  input  logic               RESET,
  threshold_actor_if.slave   io,
  output logic [31:0]        FRAME_FG,
  output logic               FRAME_DONE
);

  localparam int unsigned     CNT_W    = clog2(longint'(FRAME_PIXELS) + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  logic               ack;
  logic               send;
  logic               fg;
  logic               buf_empty;
  logic               buf_full;
  logic [PIXEL_W-1:0] buf_head;
  logic [CNT_W-1:0]   pix_cnt;
  logic [CNT_W-1:0]   fg_cnt;
  logic [CNT_W-1:0]   fg_inc;
  logic               unused_ok;

  assign unused_ok = ^{io.In1_COUNT, io.Out1_ACK};

  // Acceptance looks only at the current occupancy, so a pop in the same cycle
  // never opens a slot. Nothing is accepted while reset is held.
  assign ack  = io.In1_SEND & ~buf_full & ~RESET;
  assign send = ~buf_empty & io.Out1_RDY;
  assign fg   = (io.In1_DATA > THRESHOLD);

  threshold_fifo2 u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (ack),
    .pop   (send),
    .din   (fg ? FG_VAL : BG_VAL),
    .dout  (buf_head),
    .empty (buf_empty),
    .full  (buf_full)
  );

  assign io.In1_ACK    = ack;
  assign io.Out1_SEND  = send;
  assign io.Out1_DATA  = buf_empty ? '0 : buf_head;
  assign io.Out1_COUNT = TOKEN_COUNT;

  // Count including the pixel being accepted; cannot overflow since it never
  // exceeds FRAME_PIXELS.
  assign fg_inc = fg_cnt + CNT_W'(fg);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pix_cnt    <= '0;
      fg_cnt     <= '0;
      FRAME_FG   <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      if (ack) begin
        if (pix_cnt == LAST_PIX) begin
          pix_cnt    <= '0;
          fg_cnt     <= '0;
          FRAME_FG   <= 32'(fg_inc);
          FRAME_DONE <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + CNT_W'(1);
          fg_cnt  <= fg_inc;
        end
      end
    end
  end

endmodule
